// File: rtl/addr_gen_hc_wr_pkg.sv
// Shared LSTM H/C memory package.
// Holds the forward-pass state encoding and the H/C memory layout constants
// used by both the H/C read and write address generators.
//   Layout: timestep t (t = -1 .. TIMESTEP-1) occupies addresses
//           HC_CLEAR_BASE + (t+1)*stride .. + stride-1, stride = NUM_CELL.
package addr_gen_hc_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // The t = -1 region starts at address 0 so the reader sees zeros there.
    localparam int unsigned HC_CLEAR_BASE = 0;

    // One timestep of H/C data is one word per cell.
    function automatic int unsigned hc_stride(input int unsigned num_cell);
        return num_cell;
    endfunction

    // First address of timestep t = 0, directly after the clear region.
    function automatic int unsigned hc_run_base(input int unsigned num_cell);
        return HC_CLEAR_BASE + hc_stride(num_cell);
    endfunction

endpackage

// File: rtl/addr_gen_hc_wr_if.sv
// Bus bundle for addr_gen_hc_wr.
//   master: drives start / i_valid / i_h / i_c, observes the write port.
//   slave : the generator; drives the H/C write port, o_busy, o_done and
//           dbg_state (current FSM state, for checkers).
// Handshake: i_valid has no back-pressure; a result presented with i_valid=1
// on a rising edge while the generator is in RUN is consumed on that edge.
interface addr_gen_hc_wr_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    import addr_gen_hc_wr_pkg::*;

    logic                  start;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_h;
    logic [DATA_WIDTH-1:0] i_c;
    logic [ADDR_WIDTH-1:0] o_addr_h;
    logic [ADDR_WIDTH-1:0] o_addr_c;
    logic                  o_we_h;
    logic                  o_we_c;
    logic [DATA_WIDTH-1:0] o_data_h;
    logic [DATA_WIDTH-1:0] o_data_c;
    logic                  o_busy;
    logic                  o_done;
    state_e                dbg_state;

    modport master (
        output start, i_valid, i_h, i_c,
        input  o_addr_h, o_addr_c, o_we_h, o_we_c, o_data_h, o_data_c,
               o_busy, o_done, dbg_state
    );

    modport slave (
        input  start, i_valid, i_h, i_c,
        output o_addr_h, o_addr_c, o_we_h, o_we_c, o_data_h, o_data_c,
               o_busy, o_done, dbg_state
    );
endinterface

// File: rtl/addr_gen_hc_wr_cnt.sv
// hc_wr_cnt: cell / timestep counter for the H/C write address generator.
//   clk, rst    : clock, synchronous active-high reset (all counters 0)
//   init        : load cell=0, t=0, base=first run address
//   adv         : one write consumed; step cell, wrap into the next timestep
//   clr_phase   : while high a cell wrap does not advance t or base
//   clr_addr    : address of the current clear-region word
//   run_addr    : address of the current run-phase word (base + cell)
//   cell_last   : cell is NUM_CELL-1
//   last_write  : current word is the final one (t=TIMESTEP-1, last cell)
module hc_wr_cnt
    import addr_gen_hc_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CELL   = 53,
    parameter int TIMESTEP   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  adv,
    input  logic                  clr_phase,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [ADDR_WIDTH-1:0] run_addr,
    output logic                  cell_last,
    output logic                  last_write
);
    localparam int CELL_W = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
    localparam int T_W    = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;

    localparam logic [CELL_W-1:0]     CELL_LAST  = CELL_W'(NUM_CELL - 1);
    localparam logic [T_W-1:0]        T_LAST     = T_W'(TIMESTEP - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(hc_stride(NUM_CELL));
    localparam logic [ADDR_WIDTH-1:0] RUN_BASE   = ADDR_WIDTH'(hc_run_base(NUM_CELL));
    localparam logic [ADDR_WIDTH-1:0] CLEAR_BASE = ADDR_WIDTH'(HC_CLEAR_BASE);

    logic [CELL_W-1:0]     cell_q, cell_d;
    logic [T_W-1:0]        t_q, t_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;

    assign cell_last  = (cell_q == CELL_LAST);
    assign last_write = cell_last && (t_q == T_LAST);
    assign clr_addr   = CLEAR_BASE + ADDR_WIDTH'(cell_q);
    assign run_addr   = base_q + ADDR_WIDTH'(cell_q);

    always_comb begin
        cell_d = cell_q;
        t_d    = t_q;
        base_d = base_q;
        if (init) begin
            cell_d = '0;
            t_d    = '0;
            base_d = RUN_BASE;
        end else if (adv) begin
            if (cell_last) begin
                cell_d = '0;
                // The clear region is a single stride; its wrap only hands
                // over to timestep 0, which init already set up.
                if (!clr_phase && !last_write) begin
                    t_d    = t_q + T_W'(1);
                    base_d = base_q + STRIDE;
                end
            end else begin
                cell_d = cell_q + CELL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_q <= '0;
            t_q    <= '0;
            base_q <= '0;
        end else begin
            cell_q <= cell_d;
            t_q    <= t_d;
            base_q <= base_d;
        end
    end
endmodule

// File: rtl/addr_gen_hc_wr.sv
// addr_gen_hc_wr: H/C memory write-address generator for forward propagation.
// On start it zeroes the t = -1 region (addresses 0..NUM_CELL-1), then writes
// each LSTM cell result to (t+1)*NUM_CELL + cell, and parks in DONE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : addr_gen_hc_wr_if slave (start, i_valid, i_h, i_c in;
//              H/C write address/enable/data, o_busy, o_done, dbg_state out)
// All outputs are registered; H and C ports always carry the same address
// and enable. Address and data hold their last value while we=0.
module addr_gen_hc_wr
    import addr_gen_hc_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int TIMESTEP   = 7,
    parameter int NUM_CELL   = 53
) (
    input  logic            clk,
    input  logic            rst,
    addr_gen_hc_wr_if.slave bus
);
    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_h_q, data_h_d;
    logic [DATA_WIDTH-1:0] data_c_q, data_c_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  cnt_init, cnt_adv, cnt_clr;
    logic [ADDR_WIDTH-1:0] clr_addr, run_addr;
    logic                  cell_last, last_write;

    hc_wr_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_CELL   (NUM_CELL),
        .TIMESTEP   (TIMESTEP)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .init       (cnt_init),
        .adv        (cnt_adv),
        .clr_phase  (cnt_clr),
        .clr_addr   (clr_addr),
        .run_addr   (run_addr),
        .cell_last  (cell_last),
        .last_write (last_write)
    );

    always_comb begin
        cnt_init = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
        cnt_clr  = (state_q == ST_CLEAR);
        cnt_adv  = (state_q == ST_CLEAR) || ((state_q == ST_RUN) && bus.i_valid);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_h_d = data_h_q;
        data_c_d = data_c_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                we_d     = 1'b1;
                addr_d   = clr_addr;
                data_h_d = '0;
                data_c_d = '0;
                if (cell_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.i_valid) begin
                    we_d     = 1'b1;
                    addr_d   = run_addr;
                    data_h_d = bus.i_h;
                    data_c_d = bus.i_c;
                    if (last_write) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CLEAR) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_h_q <= '0;
            data_c_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_h_q <= data_h_d;
            data_c_q <= data_c_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_we_h    = we_q;
    assign bus.o_we_c    = we_q;
    assign bus.o_addr_h  = addr_q;
    assign bus.o_addr_c  = addr_q;
    assign bus.o_data_h  = data_h_q;
    assign bus.o_data_c  = data_c_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_addr_gen_hc_wr.sv
// Bench for addr_gen_hc_wr: a small instance (NUM_CELL=4, TIMESTEP=2) and a
// default instance (53/7), each with a reference model that tracks writes as
// one linear count, plus directed literal checks.
module tb_addr_gen_hc_wr;
    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_s [2];
    logic          valid_s [2];
    logic [DW-1:0] ih_s    [2];
    logic [DW-1:0] ic_s    [2];

    logic          we_h_o   [2];
    logic          we_c_o   [2];
    logic [AW-1:0] addr_h_o [2];
    logic [AW-1:0] addr_c_o [2];
    logic [DW-1:0] dh_o     [2];
    logic [DW-1:0] dc_o     [2];
    logic          busy_o   [2];
    logic          done_o   [2];
    logic [1:0]    st_o     [2];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt [2] = '{0, 0};

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NC = (g == 0) ? 4 : 53;
        localparam int TS = (g == 0) ? 2 : 7;

        addr_gen_hc_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

        assign bus.start   = start_s[g];
        assign bus.i_valid = valid_s[g];
        assign bus.i_h     = ih_s[g];
        assign bus.i_c     = ic_s[g];

        assign we_h_o[g]   = bus.o_we_h;
        assign we_c_o[g]   = bus.o_we_c;
        assign addr_h_o[g] = bus.o_addr_h;
        assign addr_c_o[g] = bus.o_addr_c;
        assign dh_o[g]     = bus.o_data_h;
        assign dc_o[g]     = bus.o_data_c;
        assign busy_o[g]   = bus.o_busy;
        assign done_o[g]   = bus.o_done;
        assign st_o[g]     = bus.dbg_state;

        addr_gen_hc_wr #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .TIMESTEP   (TS),
            .NUM_CELL   (NC)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Model: mode 0 idle, 1 clear, 2 run, 3 done; cnt counts words
        // written in the current phase, so run word n lands at NC + n.
        int            m_mode = 0;
        int            m_cnt  = 0;
        bit            m_live = 1'b0;
        logic          e_we   = 1'b0;
        logic [AW-1:0] e_addr = '0;
        logic [DW-1:0] e_dh   = '0;
        logic [DW-1:0] e_dc   = '0;

        always @(posedge clk) begin
            m_live = 1'b1;
            if (rst) begin
                m_mode = 0; m_cnt = 0;
                e_we = 1'b0; e_addr = '0; e_dh = '0; e_dc = '0;
            end else begin
                case (m_mode)
                    1: begin
                        e_we = 1'b1; e_addr = AW'(m_cnt); e_dh = '0; e_dc = '0;
                        m_cnt++;
                        if (m_cnt == NC) begin m_mode = 2; m_cnt = 0; end
                    end
                    2: begin
                        if (valid_s[g]) begin
                            e_we = 1'b1; e_addr = AW'(NC + m_cnt);
                            e_dh = ih_s[g]; e_dc = ic_s[g];
                            m_cnt++;
                            if (m_cnt == NC * TS) m_mode = 3;
                        end else begin
                            e_we = 1'b0;
                        end
                    end
                    default: begin
                        e_we = 1'b0;
                        if (start_s[g]) begin m_mode = 1; m_cnt = 0; end
                    end
                endcase
            end
        end

        always @(negedge clk) begin
            if (m_live) begin
                check("we_h",   g, 32'(we_h_o[g]),   32'(e_we));
                check("we_c",   g, 32'(we_c_o[g]),   32'(e_we));
                check("addr_h", g, 32'(addr_h_o[g]), 32'(e_addr));
                check("addr_c", g, 32'(addr_c_o[g]), 32'(e_addr));
                check("data_h", g, 32'(dh_o[g]),     32'(e_dh));
                check("data_c", g, 32'(dc_o[g]),     32'(e_dc));
                check("busy",   g, 32'(busy_o[g]),   32'(m_mode == 1 || m_mode == 2));
                check("done",   g, 32'(done_o[g]),   32'(m_mode == 3));
                check("state",  g, 32'(st_o[g]),     32'(m_mode));
                if (we_h_o[g]) wr_cnt[g]++;
            end
        end
    end

    // Inputs change 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start_s[d] = 1'b1;
        step();
        start_s[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; valid_s[d] = 1'b0; ih_s[d] = '0; ic_s[d] = '0;
        end
        repeat (3) step();
        rst = 1'b0;
        check("rst_addr", 0, 32'(addr_h_o[0]), 32'h0);
        check("rst_busy", 0, 32'(busy_o[0]),   32'h0);
        check("rst_done", 1, 32'(done_o[1]),   32'h0);

        // Clear phase with i_valid held high and junk data on the inputs.
        valid_s[0] = 1'b1; ih_s[0] = 16'hbeef; ic_s[0] = 16'hcafe;
        pulse_start(0);
        check("clr_wait_we", 0, 32'(we_h_o[0]), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("clr_we",   0, 32'(we_h_o[0]),   32'h1);
            check("clr_addr", 0, 32'(addr_h_o[0]), 32'(k));
            check("clr_data", 0, 32'(dh_o[0]),     32'h0);
        end
        valid_s[0] = 1'b0;
        check("clr_busy", 0, 32'(busy_o[0]), 32'h1);

        // Back-to-back run, start pulsed mid-run must be ignored.
        for (int k = 0; k < 8; k++) begin
            valid_s[0] = 1'b1; ih_s[0] = DW'(10 + k); ic_s[0] = DW'(10 + k);
            start_s[0] = (k == 3);
            step();
            check("run_addr", 0, 32'(addr_h_o[0]), 32'(4 + k));
            check("run_data", 0, 32'(dc_o[0]),     32'(10 + k));
        end
        valid_s[0] = 1'b0; start_s[0] = 1'b0;
        check("run_done", 0, 32'(done_o[0]), 32'h1);
        step();
        check("done_we", 0, 32'(we_h_o[0]), 32'h0);

        // i_valid in DONE writes nothing; start restarts the clear at 0.
        valid_s[0] = 1'b1; ih_s[0] = 16'h0063;
        repeat (3) step();
        valid_s[0] = 1'b0;
        check("done_wr_cnt", 0, 32'(wr_cnt[0]), 32'd12);
        pulse_start(0);
        check("restart_done", 0, 32'(done_o[0]), 32'h0);
        check("restart_busy", 0, 32'(busy_o[0]), 32'h1);
        step();
        check("restart_addr", 0, 32'(addr_h_o[0]), 32'h0);
        repeat (3) step();

        // Default instance: valid every third cycle through the whole run.
        pulse_start(1);
        repeat (53) step();
        check("gap_clr_cnt", 1, 32'(wr_cnt[1]), 32'd53);
        for (int n = 0; n < 371; n++) begin
            valid_s[1] = 1'b1; ih_s[1] = DW'(n); ic_s[1] = DW'(n ^ 16'h5a5a);
            step();
            valid_s[1] = 1'b0;
            if (n == 0)  check("gap_first", 1, 32'(addr_h_o[1]), 32'd53);
            if (n == 53) check("gap_t1",    1, 32'(addr_h_o[1]), 32'd106);
            repeat (2) step();
        end
        check("gap_done",   1, 32'(done_o[1]),   32'h1);
        check("gap_last",   1, 32'(addr_h_o[1]), 32'd423);
        check("gap_writes", 1, 32'(wr_cnt[1]),   32'd424);

        // Reset mid-run at t=2, cell=10, then a clean restart.
        pulse_start(1);
        repeat (53) step();
        for (int n = 0; n < 116; n++) begin
            valid_s[1] = 1'b1; ih_s[1] = DW'(16'h1000 + n); ic_s[1] = DW'(n);
            step();
        end
        valid_s[1] = 1'b0;
        check("pre_rst_addr", 1, 32'(addr_h_o[1]), 32'd168);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_addr",  1, 32'(addr_h_o[1]), 32'h0);
        check("mid_rst_data",  1, 32'(dh_o[1]),     32'h0);
        check("mid_rst_state", 1, 32'(st_o[1]),     32'h0);
        pulse_start(1);
        step();
        check("post_rst_clr", 1, 32'(addr_h_o[1]), 32'h0);
        repeat (52) step();
        valid_s[1] = 1'b1; ih_s[1] = 16'h0777;
        step();
        valid_s[1] = 1'b0;
        check("post_rst_run", 1, 32'(addr_h_o[1]), 32'd53);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
